// File: rtl/cpu_boot_loader.sv
// CPU bring-up sequencer: receives a program image over a byte link, writes it
// into instruction memory, verifies an XOR checksum and then releases CPU reset.
module cpu_boot_loader #(
    parameter int INSTR_WIDTH = 17,
    parameter int ADDR_WIDTH  = 8,
    parameter int RST_HOLD    = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [7:0]             rx_data,
    input  logic                   rx_valid,
    output logic                   rx_ready,
    output logic                   imem_we,
    output logic [ADDR_WIDTH-1:0]  imem_addr,
    output logic [INSTR_WIDTH-1:0] imem_wdata,
    output logic                   cpu_rst,
    output logic                   busy,
    output logic                   done,
    output logic                   err
);

    localparam int BYTES    = (INSTR_WIDTH + 7) / 8;
    localparam int LOW_BITS = INSTR_WIDTH - 8 * (BYTES - 1);
    localparam int BIDX_W   = (BYTES > 1) ? $clog2(BYTES) : 1;
    localparam int HOLD_W   = (RST_HOLD > 1) ? $clog2(RST_HOLD) : 1;
    // Bits of a word's leading byte that fall above INSTR_WIDTH and must be zero.
    localparam logic [15:0] HI_MASK_W = 16'h00FF << LOW_BITS;
    localparam logic [7:0]  HI_MASK   = HI_MASK_W[7:0];
    localparam logic [8:0]  MAX_HDR   = 9'((1 << ADDR_WIDTH) - 1);
    localparam logic [BIDX_W-1:0] LAST_BYTE = BIDX_W'(BYTES - 1);
    localparam logic [HOLD_W-1:0] LAST_HOLD = HOLD_W'(RST_HOLD - 1);

    typedef enum logic [3:0] {
        IDLE  = 4'd0,
        HDR   = 4'd1,
        DATA  = 4'd2,
        WRITE = 4'd3,
        CSUM  = 4'd4,
        HOLD  = 4'd5,
        RUN   = 4'd6,
        ERR   = 4'd7
    } state_t;

    state_t                  state_r;
    state_t                  state_next_s;
    logic [ADDR_WIDTH-1:0]   word_idx_r;
    logic [ADDR_WIDTH-1:0]   last_idx_r;
    logic [BIDX_W-1:0]       byte_idx_r;
    logic [HOLD_W-1:0]       hold_cnt_r;
    logic [7:0]              csum_r;
    logic [INSTR_WIDTH-1:0]  asm_r;
    logic [INSTR_WIDTH-1:0]  asm_next_s;
    logic                    accept_s;
    logic                    hdr_bad_s;
    logic                    first_bad_s;

    logic                    rx_ready_r;
    logic                    imem_we_r;
    logic [ADDR_WIDTH-1:0]   imem_addr_r;
    logic [INSTR_WIDTH-1:0]  imem_wdata_r;
    logic                    cpu_rst_r;
    logic                    busy_r;
    logic                    done_r;
    logic                    err_r;

    assign accept_s    = rx_valid & rx_ready_r;
    assign asm_next_s  = INSTR_WIDTH'({asm_r, rx_data});
    assign hdr_bad_s   = ({1'b0, rx_data} > MAX_HDR);
    assign first_bad_s = (byte_idx_r == {BIDX_W{1'b0}}) && ((rx_data & HI_MASK) != 8'h00);

    // Next-state selection for the load sequencer.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                if (start) state_next_s = HDR;
                else       state_next_s = IDLE;
            end
            HDR: begin
                if (accept_s) state_next_s = hdr_bad_s ? ERR : DATA;
                else          state_next_s = HDR;
            end
            DATA: begin
                if (accept_s) begin
                    if (first_bad_s)                   state_next_s = ERR;
                    else if (byte_idx_r == LAST_BYTE)  state_next_s = WRITE;
                    else                               state_next_s = DATA;
                end else begin
                    state_next_s = DATA;
                end
            end
            WRITE: begin
                if (word_idx_r == last_idx_r) state_next_s = CSUM;
                else                          state_next_s = DATA;
            end
            CSUM: begin
                if (accept_s) state_next_s = (rx_data == csum_r) ? HOLD : ERR;
                else          state_next_s = CSUM;
            end
            HOLD: begin
                if (hold_cnt_r == LAST_HOLD) state_next_s = RUN;
                else                         state_next_s = HOLD;
            end
            RUN: begin
                if (start) state_next_s = HDR;
                else       state_next_s = RUN;
            end
            ERR: begin
                if (start) state_next_s = HDR;
                else       state_next_s = ERR;
            end
            default: state_next_s = IDLE;
        endcase
    end

    // State, datapath and outputs registered from the next state so every output is Moore.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= IDLE;
            word_idx_r   <= '0;
            last_idx_r   <= '0;
            byte_idx_r   <= '0;
            hold_cnt_r   <= '0;
            csum_r       <= 8'h00;
            asm_r        <= '0;
            rx_ready_r   <= 1'b0;
            imem_we_r    <= 1'b0;
            imem_addr_r  <= '0;
            imem_wdata_r <= '0;
            cpu_rst_r    <= 1'b1;
            busy_r       <= 1'b0;
            done_r       <= 1'b0;
            err_r        <= 1'b0;
        end else begin
            state_r    <= state_next_s;
            rx_ready_r <= (state_next_s == HDR) || (state_next_s == DATA) || (state_next_s == CSUM);
            busy_r     <= (state_next_s == HDR) || (state_next_s == DATA) || (state_next_s == WRITE) ||
                          (state_next_s == CSUM) || (state_next_s == HOLD);
            imem_we_r  <= (state_next_s == WRITE);
            cpu_rst_r  <= (state_next_s != RUN);
            done_r     <= (state_next_s == RUN);
            err_r      <= (state_next_s == ERR);

            if (state_next_s == WRITE) begin
                imem_addr_r  <= word_idx_r;
                imem_wdata_r <= asm_next_s;
            end

            case (state_r)
                HDR: begin
                    if (accept_s && !hdr_bad_s) begin
                        last_idx_r <= rx_data[ADDR_WIDTH-1:0];
                        word_idx_r <= '0;
                        byte_idx_r <= '0;
                        csum_r     <= 8'h00;
                        asm_r      <= '0;
                    end
                end
                DATA: begin
                    if (accept_s) begin
                        asm_r      <= asm_next_s;
                        csum_r     <= csum_r ^ rx_data;
                        byte_idx_r <= (byte_idx_r == LAST_BYTE) ? {BIDX_W{1'b0}} : byte_idx_r + 1'b1;
                    end
                end
                WRITE: begin
                    // The final word leaves the index at N-1 so it never wraps.
                    if (word_idx_r != last_idx_r) word_idx_r <= word_idx_r + 1'b1;
                end
                HOLD: begin
                    hold_cnt_r <= (hold_cnt_r == LAST_HOLD) ? {HOLD_W{1'b0}} : hold_cnt_r + 1'b1;
                end
                default: begin
                    hold_cnt_r <= {HOLD_W{1'b0}};
                end
            endcase
        end
    end

    assign rx_ready   = rx_ready_r;
    assign imem_we    = imem_we_r;
    assign imem_addr  = imem_addr_r;
    assign imem_wdata = imem_wdata_r;
    assign cpu_rst    = cpu_rst_r;
    assign busy       = busy_r;
    assign done       = done_r;
    assign err        = err_r;

endmodule

// File: tb/tb_cpu_boot_loader.sv
// Directed bench for cpu_boot_loader: nominal, bad checksum, illegal bits,
// backpressure, maximum image, reset and restart scenarios.
module tb_cpu_boot_loader;

    logic        clk;
    logic        rst;
    logic        start;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic        imem_we;
    logic [7:0]  imem_addr;
    logic [16:0] imem_wdata;
    logic        cpu_rst;
    logic        busy;
    logic        done;
    logic        err;

    int tests_run;
    int tests_failed;
    int wr_addr_q[$];
    int wr_data_q[$];
    logic [7:0] nom_img [0:6];

    cpu_boot_loader dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .rx_ready   (rx_ready),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .cpu_rst    (cpu_rst),
        .busy       (busy),
        .done       (done),
        .err        (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Record every memory write seen during a cycle.
    always @(negedge clk) begin
        if (imem_we) begin
            wr_addr_q.push_back(int'(imem_addr));
            wr_data_q.push_back(int'(imem_wdata));
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        int waited;
        rx_data  = b;
        rx_valid = 1'b1;
        waited   = 0;
        while (rx_ready !== 1'b1 && waited < 50) begin
            tick();
            waited++;
        end
        if (rx_ready !== 1'b1) check_eq("rx_ready_timeout", {31'd0, rx_ready}, 32'd1);
        tick();
        rx_valid = 1'b0;
        repeat (gap) tick();
    endtask

    task automatic wait_run();
        int waited;
        waited = 0;
        while (done !== 1'b1 && waited < 50) begin
            tick();
            waited++;
        end
        check_eq("reach_run", {31'd0, done}, 32'd1);
    endtask

    task automatic clear_writes();
        wr_addr_q.delete();
        wr_data_q.delete();
    endtask

    task automatic check_nominal_writes(input string tag);
        check_eq({tag, "_wr_count"}, wr_addr_q.size(), 32'd2);
        if (wr_addr_q.size() == 2) begin
            check_eq({tag, "_wr0_addr"}, wr_addr_q[0], 32'd0);
            check_eq({tag, "_wr0_data"}, wr_data_q[0], 32'h1ABCD);
            check_eq({tag, "_wr1_addr"}, wr_addr_q[1], 32'd1);
            check_eq({tag, "_wr1_data"}, wr_data_q[1], 32'h00012);
        end
    endtask

    // Sends header, words and the given checksum; optionally checks the first WRITE cycle.
    task automatic load_nominal(input logic [7:0] csum, input int gap, input bit chk_write);
        for (int i = 0; i < 7; i++) begin
            send_byte(nom_img[i], gap);
            if (chk_write && i == 3) begin
                check_eq("write_we", {31'd0, imem_we}, 32'd1);
                check_eq("write_rx_ready", {31'd0, rx_ready}, 32'd0);
                check_eq("write_addr", {24'd0, imem_addr}, 32'd0);
                check_eq("write_data", {15'd0, imem_wdata}, 32'h1ABCD);
            end
        end
        send_byte(csum, gap);
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        rst      = 1'b1;
        start    = 1'b0;
        rx_data  = 8'h00;
        rx_valid = 1'b0;
        nom_img[0] = 8'h01; nom_img[1] = 8'h01; nom_img[2] = 8'hAB; nom_img[3] = 8'hCD;
        nom_img[4] = 8'h00; nom_img[5] = 8'h00; nom_img[6] = 8'h12;
        tick();
        tick();
        rst = 1'b0;

        check_eq("rst_cpu_rst", {31'd0, cpu_rst}, 32'd1);
        check_eq("rst_rx_ready", {31'd0, rx_ready}, 32'd0);
        check_eq("rst_busy", {31'd0, busy}, 32'd0);
        check_eq("rst_done", {31'd0, done}, 32'd0);
        check_eq("rst_err", {31'd0, err}, 32'd0);
        check_eq("rst_we", {31'd0, imem_we}, 32'd0);
        check_eq("rst_addr", {24'd0, imem_addr}, 32'd0);
        check_eq("rst_wdata", {15'd0, imem_wdata}, 32'd0);

        // Nominal load with exact hold length.
        clear_writes();
        pulse_start();
        check_eq("hdr_rx_ready", {31'd0, rx_ready}, 32'd1);
        check_eq("hdr_busy", {31'd0, busy}, 32'd1);
        load_nominal(8'h75, 0, 1'b1);
        for (int i = 0; i < 4; i++) begin
            check_eq("hold_cpu_rst", {31'd0, cpu_rst}, 32'd1);
            check_eq("hold_busy", {31'd0, busy}, 32'd1);
            check_eq("hold_rx_ready", {31'd0, rx_ready}, 32'd0);
            tick();
        end
        check_eq("run_cpu_rst", {31'd0, cpu_rst}, 32'd0);
        check_eq("run_done", {31'd0, done}, 32'd1);
        check_eq("run_busy", {31'd0, busy}, 32'd0);
        check_nominal_writes("nominal");

        // Start from RUN re-enters HDR; then a bad checksum load.
        clear_writes();
        pulse_start();
        check_eq("restart_cpu_rst", {31'd0, cpu_rst}, 32'd1);
        check_eq("restart_done", {31'd0, done}, 32'd0);
        check_eq("restart_rx_ready", {31'd0, rx_ready}, 32'd1);
        load_nominal(8'h74, 0, 1'b0);
        check_eq("badcs_err", {31'd0, err}, 32'd1);
        check_eq("badcs_cpu_rst", {31'd0, cpu_rst}, 32'd1);
        check_eq("badcs_done", {31'd0, done}, 32'd0);
        check_nominal_writes("badcs");
        clear_writes();
        pulse_start();
        check_eq("recover_err_clear", {31'd0, err}, 32'd0);
        load_nominal(8'h75, 0, 1'b0);
        wait_run();
        check_eq("recover_err", {31'd0, err}, 32'd0);
        check_nominal_writes("recover");

        // Illegal high bits in a word's leading byte.
        clear_writes();
        pulse_start();
        send_byte(8'h00, 0);
        send_byte(8'h02, 0);
        check_eq("illegal_err", {31'd0, err}, 32'd1);
        check_eq("illegal_rx_ready", {31'd0, rx_ready}, 32'd0);
        repeat (5) tick();
        check_eq("illegal_rx_ready_later", {31'd0, rx_ready}, 32'd0);
        check_eq("illegal_no_writes", wr_addr_q.size(), 32'd0);

        // Backpressure: one valid cycle then two idle cycles per byte.
        clear_writes();
        pulse_start();
        load_nominal(8'h75, 2, 1'b0);
        wait_run();
        check_eq("bp_cpu_rst", {31'd0, cpu_rst}, 32'd0);
        check_nominal_writes("bp");

        // Start during HOLD is ignored.
        clear_writes();
        pulse_start();
        load_nominal(8'h75, 0, 1'b0);
        pulse_start();
        check_eq("hold_start_ignored_rx", {31'd0, rx_ready}, 32'd0);
        check_eq("hold_start_busy", {31'd0, busy}, 32'd1);
        tick();
        tick();
        check_eq("hold_start_cpu_rst", {31'd0, cpu_rst}, 32'd1);
        tick();
        check_eq("hold_start_run", {31'd0, done}, 32'd1);
        check_eq("hold_start_cpu_rst_run", {31'd0, cpu_rst}, 32'd0);

        // Maximum image: 256 words, word k = k, checksum 0.
        clear_writes();
        pulse_start();
        send_byte(8'hFF, 0);
        for (int k = 0; k < 256; k++) begin
            send_byte(8'h00, 0);
            send_byte(8'h00, 0);
            send_byte(8'(k), 0);
        end
        send_byte(8'h00, 0);
        wait_run();
        check_eq("max_wr_count", wr_addr_q.size(), 32'd256);
        for (int k = 0; k < wr_addr_q.size() && k < 256; k++) begin
            check_eq("max_addr", wr_addr_q[k], k);
            check_eq("max_data", wr_data_q[k], k);
        end

        // Reset in the middle of DATA.
        pulse_start();
        send_byte(8'h00, 0);
        send_byte(8'h01, 0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_eq("midrst_cpu_rst", {31'd0, cpu_rst}, 32'd1);
        check_eq("midrst_busy", {31'd0, busy}, 32'd0);
        check_eq("midrst_done", {31'd0, done}, 32'd0);
        check_eq("midrst_err", {31'd0, err}, 32'd0);
        check_eq("midrst_rx_ready", {31'd0, rx_ready}, 32'd0);
        check_eq("midrst_addr", {24'd0, imem_addr}, 32'd0);
        tick();
        check_eq("midrst_idle_rx_ready", {31'd0, rx_ready}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
